// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
// axi_sram_slave : AXI4 slave over a 64-bit word array; one FSM serialises
//                  read/write bursts onto a single port with fair arbitration.
// Revision       : 1.0
// ============================================================================
module axi_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          ID_W        = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            awvalid,
  output logic            awready,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [7:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  input  logic            wvalid,
  output logic            wready,
  input  logic [63:0]     wdata,
  input  logic [7:0]      wstrb,
  input  logic            wlast,
  output logic            bvalid,
  input  logic            bready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  input  logic            arvalid,
  output logic            arready,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  output logic            rvalid,
  input  logic            rready,
  output logic [ID_W-1:0] rid,
  output logic [1:0]      rresp,
  output logic [63:0]     rdata,
  output logic            rlast
);

  localparam int          IDX_W       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] TOP_ADDR    = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd8;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [1:0]  BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {IDLE, RD, WR_DATA, WR_RESP} state_t;
  state_t state, state_nxt;

  logic [63:0] mem [DEPTH_WORDS];

  logic [31:0] addr;
  logic [7:0]  len;
  logic [7:0]  beat_cnt;
  logic [2:0]  size;
  logic [1:0]  burst;
  logic        bad;
  logic [1:0]  err;
  logic        rr_last_read;

  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE_ADDR) && ({1'b0, a} < TOP_ADDR);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 3);
  endfunction

  logic grant_rd, grant_wr;
  logic ar_hs, aw_hs, r_hs, w_hs, b_hs;

  assign grant_rd = arvalid && (!awvalid || !rr_last_read);
  assign grant_wr = awvalid && (!arvalid ||  rr_last_read);
  assign ar_hs    = arvalid && arready;
  assign aw_hs    = awvalid && awready;
  assign r_hs     = rvalid && rready;
  assign w_hs     = wvalid && wready;
  assign b_hs     = bvalid && bready;

  logic [31:0] next_addr;
  assign next_addr = (burst == BURST_INCR) ? addr + (32'd1 << size) : addr;

  // The beat loaded into the R registers is either the first one (still on
  // the AR bus) or the one after the beat being accepted now.
  logic [31:0] rd_addr;
  logic        rd_bad;
  logic [1:0]  rd_resp;
  logic [63:0] rd_word;

  always_comb begin
    rd_addr = next_addr;
    rd_bad  = bad;
    if (state == IDLE) begin
      rd_addr = araddr;
      rd_bad  = arburst[1] || (arsize > 3'd3);
    end
    rd_word = mem[word_idx(rd_addr)];
    if (rd_bad)                 rd_resp = RESP_SLVERR;
    else if (!in_range(rd_addr)) rd_resp = RESP_DECERR;
    else                        rd_resp = RESP_OKAY;
  end

  logic       w_ok;
  logic [1:0] w_err;

  always_comb begin
    w_ok  = !bad && in_range(addr);
    w_err = RESP_OKAY;
    if (bad)                  w_err = RESP_SLVERR;
    else if (!in_range(addr)) w_err = RESP_DECERR;
    if (wlast != (beat_cnt == len)) w_err = w_err | RESP_SLVERR;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arready   = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    case (state)
      IDLE: begin
        arready = rst && grant_rd;
        awready = rst && grant_wr;
        if (arready)      state_nxt = RD;
        else if (awready) state_nxt = WR_DATA;
      end
      RD:      if (rvalid && rready && rlast) state_nxt = IDLE;
      WR_DATA: begin
        wready = 1'b1;
        if (wvalid && wlast) state_nxt = WR_RESP;
      end
      WR_RESP: if (bready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rvalid       <= 1'b0;
      rlast        <= 1'b0;
      rdata        <= '0;
      rresp        <= '0;
      rid          <= '0;
      bvalid       <= 1'b0;
      bresp        <= '0;
      bid          <= '0;
      rr_last_read <= 1'b0;
      addr         <= '0;
      len          <= '0;
      size         <= '0;
      burst        <= '0;
      bad          <= 1'b0;
      beat_cnt     <= '0;
      err          <= '0;
    end else begin
      if (ar_hs) begin
        rr_last_read <= 1'b1;
        rid          <= arid;
        addr         <= araddr;
        len          <= arlen;
        size         <= arsize;
        burst        <= arburst;
        bad          <= rd_bad;
        beat_cnt     <= '0;
        rvalid       <= 1'b1;
        rlast        <= (arlen == 8'd0);
        rdata        <= (rd_resp == RESP_OKAY) ? rd_word : 64'd0;
        rresp        <= rd_resp;
      end else if (r_hs) begin
        if (rlast) begin
          rvalid <= 1'b0;
          rlast  <= 1'b0;
        end else begin
          addr     <= next_addr;
          beat_cnt <= beat_cnt + 8'd1;
          rlast    <= (beat_cnt + 8'd1 == len);
          rdata    <= (rd_resp == RESP_OKAY) ? rd_word : 64'd0;
          rresp    <= rd_resp;
        end
      end

      if (aw_hs) begin
        rr_last_read <= 1'b0;
        bid          <= awid;
        addr         <= awaddr;
        len          <= awlen;
        size         <= awsize;
        burst        <= awburst;
        bad          <= awburst[1] || (awsize > 3'd3);
        beat_cnt     <= '0;
        err          <= RESP_OKAY;
      end else if (w_hs) begin
        // OR-merging keeps DECERR (11) above SLVERR (10) above OKAY.
        addr     <= next_addr;
        beat_cnt <= beat_cnt + 8'd1;
        err      <= err | w_err;
        if (wlast) begin
          bvalid <= 1'b1;
          bresp  <= err | w_err;
        end
      end

      if (b_hs) bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_hs && w_ok) begin
      for (int b = 0; b < 8; b++) begin
        if (wstrb[b]) mem[word_idx(addr)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// ============================================================================
// tb_axi_sram_slave : randomized self-checking bench with a word-array model.
// Revision          : 1.0
// ============================================================================
module tb_axi_sram_slave;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          ID_W  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            awvalid = 1'b0, awready;
  logic [ID_W-1:0] awid = '0;
  logic [31:0]     awaddr = '0;
  logic [7:0]      awlen = '0;
  logic [2:0]      awsize = '0;
  logic [1:0]      awburst = '0;
  logic            wvalid = 1'b0, wready;
  logic [63:0]     wdata = '0;
  logic [7:0]      wstrb = '0;
  logic            wlast = 1'b0;
  logic            bvalid, bready = 1'b0;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            arvalid = 1'b0, arready;
  logic [ID_W-1:0] arid = '0;
  logic [31:0]     araddr = '0;
  logic [7:0]      arlen = '0;
  logic [2:0]      arsize = '0;
  logic [1:0]      arburst = '0;
  logic            rvalid, rready = 1'b0;
  logic [ID_W-1:0] rid;
  logic [1:0]      rresp;
  logic [63:0]     rdata;
  logic            rlast;

  axi_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rresp(rresp),
    .rdata(rdata), .rlast(rlast)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] mm [DEPTH];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];
  logic [1:0]  eb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: beat i of a burst lives at start + i*bytes (INCR) or start (FIXED).
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i,
                                            input logic [2:0] sz, input logic [1:0] bu);
    if (bu == 2'b01) return a + 32'(i << sz);
    return a;
  endfunction

  function automatic logic unsupported(input logic [2:0] sz, input logic [1:0] bu);
    return (bu == 2'b10) || (bu == 2'b11) || (sz > 3'd3);
  endfunction

  function automatic logic inside_mem(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + 8 * DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 8);
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a, input int i,
                                          input logic [2:0] sz, input logic [1:0] bu);
    if (unsupported(sz, bu)) return 2'b10;
    if (!inside_mem(beat_addr(a, i, sz, bu))) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [63:0] exp_data(input logic [31:0] a, input int i,
                                           input logic [2:0] sz, input logic [1:0] bu);
    if (exp_resp(a, i, sz, bu) != 2'b00) return 64'd0;
    return mm[widx(beat_addr(a, i, sz, bu))];
  endfunction

  task automatic addr_rd(input logic [ID_W-1:0] id, input logic [31:0] a, input int len,
                         input logic [2:0] sz, input logic [1:0] bu);
    int cyc = 0;
    @(negedge clk);
    arvalid = 1'b1; arid = id; araddr = a; arlen = 8'(len); arsize = sz; arburst = bu;
    #1;
    while (!arready && cyc < 50) begin @(negedge clk); #1; cyc++; end
    check("ar_handshake", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  // mode 0: rready always high, 1: pattern 1,0,0 repeating, 2: random.
  task automatic data_rd(input logic [ID_W-1:0] id, input logic [31:0] a, input int len,
                         input logic [2:0] sz, input logic [1:0] bu, input int mode);
    int   beat = 0;
    int   cyc  = 0;
    logic go;
    while (beat <= len && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (mode == 1)      go = ((cyc % 3) == 1);
      else if (mode == 2) go = 1'($urandom_range(0, 1));
      else                go = 1'b1;
      if (cyc == 1) check("r_valid_first", rvalid, 1);
      if (rvalid) begin
        check("r_data", rdata, exp_data(a, beat, sz, bu));
        check("r_resp", rresp, exp_resp(a, beat, sz, bu));
        check("r_last", rlast, beat == len);
        check("r_id", rid, id);
        if (go) beat++;
        rready = go;
      end else begin
        if (mode == 0) check("r_bubble", rvalid, 1);
        rready = 1'b0;
      end
    end
    check("r_beats", beat, len + 1);
    @(negedge clk);
    rready = 1'b0;
    check("r_done", rvalid, 0);
  endtask

  task automatic addr_wr(input logic [ID_W-1:0] id, input logic [31:0] a, input int len,
                         input logic [2:0] sz, input logic [1:0] bu);
    int cyc = 0;
    @(negedge clk);
    awvalid = 1'b1; awid = id; awaddr = a; awlen = 8'(len); awsize = sz; awburst = bu;
    #1;
    while (!awready && cyc < 50) begin @(negedge clk); #1; cyc++; end
    check("aw_handshake", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic data_wr(input logic [31:0] a, input int len, input logic [2:0] sz,
                         input logic [1:0] bu, input int last_beat, output logic [1:0] e);
    logic        dec = 1'b0;
    logic        slv = 1'b0;
    logic [31:0] ba;
    int          cyc;
    for (int i = 0; i <= last_beat; i++) begin
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_beat);
      @(negedge clk);
      cyc = 0;
      while (!wready && cyc < 50) begin @(negedge clk); cyc++; end
      check("w_ready", wready, 1);
      @(posedge clk); #1;
      ba = beat_addr(a, i, sz, bu);
      if (unsupported(sz, bu)) slv = 1'b1;
      else if (!inside_mem(ba)) dec = 1'b1;
      else begin
        for (int b = 0; b < 8; b++)
          if (ws[i][b]) mm[widx(ba)][8*b +: 8] = wd[i][8*b +: 8];
      end
      if ((i == last_beat) != (i == len)) slv = 1'b1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    e = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
  endtask

  task automatic resp_wr(input logic [ID_W-1:0] id, input logic [1:0] exp);
    int cyc  = 0;
    int hold = $urandom_range(0, 2);
    @(negedge clk);
    while (!bvalid && cyc < 50) begin @(negedge clk); cyc++; end
    check("b_valid", bvalid, 1);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("b_hold", {bvalid, bresp}, {1'b1, exp});
    end
    check("b_resp", bresp, exp);
    check("b_id", bid, id);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    check("b_done", bvalid, 0);
  endtask

  task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] a, input int len,
                          input logic [2:0] sz, input logic [1:0] bu, input int last_beat);
    logic [1:0] e;
    addr_wr(id, a, len, sz, bu);
    data_wr(a, len, sz, bu, last_beat, e);
    resp_wr(id, e);
  endtask

  task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] a, input int len,
                         input logic [2:0] sz, input logic [1:0] bu, input int mode);
    addr_rd(id, a, len, sz, bu);
    data_rd(id, a, len, sz, bu, mode);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    arvalid = 1'b1; awvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", {arready, awready, wready}, 0);
      check("rst_valid", {bvalid, rvalid, rlast}, 0);
      check("rst_rdata", rdata, 0);
      check("rst_ids", {rid, bid, rresp, bresp}, 0);
    end
    rst = 1'b1;
    #1;
    check("first_idle_grant", {arready, awready}, 2'b10);
    arvalid = 1'b0; awvalid = 1'b0;

    // Known contents at the low and high ends of the array.
    for (int i = 0; i < 64; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    do_write(1, BASE, 63, 3, 2'b01, 63);
    for (int i = 0; i < 64; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    do_write(1, BASE + 32'((DEPTH - 64) * 8), 63, 3, 2'b01, 63);

    for (int i = 0; i < 4; i++) begin wd[i] = 64'(i + 1); ws[i] = 8'hFF; end
    do_write(5, BASE, 3, 3, 2'b01, 3);
    do_read(9, BASE, 3, 3, 2'b01, 0);

    do_read(6, BASE + 32'd64, 7, 3, 2'b01, 1);

    wd[0] = 64'd0; ws[0] = 8'hFF;
    do_write(7, BASE + 32'd40, 0, 3, 2'b01, 0);

    // Both address channels held busy: grants must alternate R,W,R,W.
    @(negedge clk);
    arvalid = 1'b1; arid = 2; araddr = BASE + 32'd24; arlen = 0; arsize = 3; arburst = 2'b01;
    awvalid = 1'b1; awid = 3; awaddr = BASE + 32'd56; awlen = 0; awsize = 3; awburst = 2'b01;
    for (int g = 0; g < 4; g++) begin
      int cyc = 0;
      #1;
      while (!arready && !awready && cyc < 20) begin @(negedge clk); #1; cyc++; end
      check("grant_onehot", arready & awready, 0);
      check("grant_order", {arready, awready}, (g % 2 == 0) ? 2'b10 : 2'b01);
      if (arready) begin
        @(posedge clk); #1;
        data_rd(2, BASE + 32'd24, 0, 3, 2'b01, 0);
      end else if (awready) begin
        @(posedge clk); #1;
        wd[0] = {$urandom, $urandom}; ws[0] = 8'hFF;
        data_wr(BASE + 32'd56, 0, 3, 2'b01, 0, eb);
        resp_wr(3, eb);
      end
    end
    arvalid = 1'b0; awvalid = 1'b0;

    wd[0] = 64'hAAAA_BBBB_CCCC_DDDD; ws[0] = 8'h0F;
    do_write(8, BASE + 32'd40, 0, 3, 2'b01, 0);
    do_read(8, BASE + 32'd40, 0, 3, 2'b01, 0);
    check("strobe_model", mm[5], 64'h0000_0000_CCCC_DDDD);

    do_read(1, BASE + 32'(DEPTH * 8), 0, 3, 2'b01, 0);
    do_read(2, BASE, 1, 3, 2'b10, 0);

    for (int i = 0; i < 3; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    do_write(3, BASE + 32'd160, 2, 3, 2'b01, 1);

    do_read(4, BASE + 32'((DEPTH - 4) * 8), 255, 3, 2'b01, 2);
    for (int i = 0; i < 8; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
    do_write(5, BASE + 32'((DEPTH - 2) * 8), 7, 3, 2'b01, 7);
    do_read(5, BASE + 32'((DEPTH - 2) * 8), 7, 3, 2'b01, 0);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      logic [2:0]  sz;
      logic [1:0]  bu;
      int          len;
      int          r;
      sz  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      r   = $urandom_range(0, 9);
      bu  = (r == 0) ? 2'b10 : ((r < 4) ? 2'b00 : 2'b01);
      len = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) a = BASE + 32'((DEPTH - 8) * 8) + 32'($urandom_range(0, 63));
      else                           a = BASE + 32'($urandom_range(0, 31 * 8));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= len; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
        do_write(4'($urandom), a, len, sz, bu, len);
      end else begin
        do_read(4'($urandom), a, len, sz, bu, 2);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
AXI4 slave memory that sits directly downstream of the AXI crossbar. It terminates crossbar master-side traffic into an internal 64-bit word array backing main memory for simulation. A single FSM serialises read and write bursts onto one memory port with fair arbitration. Out-of-range and unsupported bursts return error responses.

Parameters:
BASE_ADDR, 32'h8000_0000, byte address of word 0
DEPTH_WORDS, 4096, number of 64-bit words (32 KiB); power of two
ID_W, 4, AXI ID width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (asserted when 0)
awvalid  in  1  write address valid
awready  out  1  write address ready
awid  in  ID_W  write ID
awaddr  in  32  write start byte address
awlen  in  8  beats minus one
awsize  in  3  bytes per beat = 1<<awsize; max 3
awburst  in  2  00 FIXED, 01 INCR, others unsupported
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  64  write data
wstrb  in  8  byte enables
wlast  in  1  last write beat
bvalid  out  1  write response valid
bready  in  1  write response ready
bid  out  ID_W  = captured awid
bresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
arvalid  in  1  read address valid
arready  out  1  read address ready
arid  in  ID_W  read ID
araddr  in  32  read start byte address
arlen  in  8  beats minus one
arsize  in  3  bytes per beat; max 3
arburst  in  2  as awburst
rvalid  out  1  read data valid
rready  in  1  read data ready
rid  out  ID_W  = captured arid
rresp  out  2  per-beat response
rdata  out  64  read data, full 64-bit lane
rlast  out  1  last read beat

Behaviour:
- Reset (rst==0 at posedge): FSM->IDLE; awready, wready, bvalid, arready, rvalid, rlast = 0; rdata, rid, bid, rresp, bresp = 0; rr_last_read = 0. Memory contents are not cleared. Reset mid-burst aborts the burst without a response.
- States: IDLE, RD, WR_DATA, WR_RESP.
- IDLE: arready = grant_rd, awready = grant_wr (combinational from valids).
  - Only one valid asserted: grant that channel.
  - Both asserted: grant read if rr_last_read==0, else grant write.
  - rr_last_read updates on every address handshake (1 on read, 0 on write).
- AR handshake at edge N:
  - Capture id, len, size, burst, address; beat_cnt = 0; go to RD.
  - Beat 0 rdata/rresp registered at the same edge, so rvalid=1 from cycle N+1.
- RD:
  - rvalid=1; rlast = (beat_cnt==len).
  - On rvalid&&rready: if !rlast, advance address and load next beat at the same edge, giving back-to-back beats with no bubble. If rlast, drop rvalid and rlast and return to IDLE.
  - If rready is low, rvalid, rdata, rlast and rresp hold stable.
- Address advance:
  - INCR: addr += (1<<size).
  - FIXED: addr unchanged.
  - Word index = (addr-BASE_ADDR)>>3, truncated to log2(DEPTH_WORDS) bits, and used only when in range.
- Range check per beat: in range iff BASE_ADDR <= addr < BASE_ADDR + 8*DEPTH_WORDS.
  - Out of range: rresp=11, rdata=0.
  - Unsupported burst (10/11) or size>3: rresp=10, rdata=0 for all len+1 beats, no memory access.
- AW handshake: capture fields, clear err flag, go to WR_DATA.
- WR_DATA:
  - wready=1.
  - Each wvalid&&wready beat writes the bytes enabled by wstrb when in range and the burst is supported; otherwise it sets the sticky err code (DECERR outranks SLVERR).
  - Address advances as for reads.
  - Beat with wlast=1: wready drops, go to WR_RESP.
  - wlast on a beat other than beat len, or beat len without wlast, sets SLVERR. The burst still terminates only on wlast.
- WR_RESP: bvalid=1, bresp = err code or 00. On bready, return to IDLE. bvalid is held stable while bready is low.
- Write data is visible to a read whose AR handshake is on or after the cycle following the last W beat.
- len=255 INCR crossing the top of the array: beats past the end return DECERR individually; beats inside are served normally.

Test Plan:
- Reset held low 3 cycles with arvalid=awvalid=1 -> all ready/valid outputs 0. After release, arready=1 in the first IDLE cycle.
- Write 0x80000000, awlen=3, INCR, size=3, wstrb=FF, data 1,2,3,4 -> bresp=00, bid=awid. Then read same, arlen=3 -> rvalid at N+1, rdata 1,2,3,4 on 4 consecutive cycles with rready=1, rlast on the 4th beat, rid=arid.
- Read burst with rready toggled 1,0,0,1,... -> no beat lost or duplicated; rdata stable while stalled.
- arvalid and awvalid both held high for 4 bursts -> grants alternate R,W,R,W.
- Write wstrb=0x0F data 0xAAAA_BBBB_CCCC_DDDD over 0 -> readback 0x0000_0000_CCCC_DDDD. Read at BASE+8*DEPTH_WORDS -> rresp=11, rdata=0.
- arburst=10 arlen=1 -> 2 beats rresp=10. awlen=2 with wlast on beat 1 -> bresp=10.
